id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage pipelined CPU, directly upstream of the EX-stage destination-register mux.
- Captures decoded control, register-file read data, register specifiers and sign-extended immediate at the end of ID. Presents them as E-stage signals: RtE, RdE and RegDstE feed the destination mux; RsE and RtE feed the hazard unit.
- Supports hazard-unit stall (hold) and flush (bubble insertion).

---
 rtl/pcpu_pkg.sv | 32 +++
 rtl/pipe_field_reg.sv | 26 ++
 rtl/id_ex_pipe_reg.sv | 127 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// Shared definitions for the 5-stage pipelined CPU: default widths, ALU
// operation encodings and the decoded control bundle carried between stages.
package pcpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_ALUC_W = 3;

  // Performance counters stop here instead of wrapping.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [DEF_ALUC_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic                  reg_write;
    logic                  memto_reg;
    logic                  mem_write;
    logic [DEF_ALUC_W-1:0] alu_control;
    logic                  alu_src;
    logic                  reg_dst;
  } ctrl_t;

  // A bubble writes nothing and steers the destination mux to register 0.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Width-parameterised pipeline field register: async active-low reset,
// load enable and a synchronous clear that dominates the enable.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: state is written with non-blocking assignments only, and the async
  // reset appears in the sensitivity list so q clears without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hazard-unit stall (hold) and flush (bubble).
// Define IDEX_PERF_CNT_EN to add saturating bubble/stall counters.
module id_ex_pipe_reg
  import pcpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int ALUC_W = DEF_ALUC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RdD,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [DATA_W-1:0] PCPlus4D,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              ALUSrcE,
  output logic              RegDstE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [REG_AW-1:0] RsE,
  output logic [REG_AW-1:0] RtE,
  output logic [REG_AW-1:0] RdE,
  output logic [DATA_W-1:0] SignImmE,
  output logic [DATA_W-1:0] PCPlus4E,
  output logic              ValidE
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]       BubbleCntE,
  output logic [31:0]       StallCntE
`endif
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  load_en;

  // Flush overrides stall inside each field register (clear beats enable).
  assign load_en = ~StallE;

  assign ctrl_d = '{
    reg_write:   RegWriteD,
    memto_reg:   MemtoRegD,
    mem_write:   MemWriteD,
    alu_control: ALUControlD,
    alu_src:     ALUSrcD,
    reg_dst:     RegDstD
  };

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (FlushE),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  pipe_field_reg #(.W(4*DATA_W)) u_data (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (FlushE),
    .d     ({RD1D, RD2D, SignImmD, PCPlus4D}),
    .q     ({RD1E, RD2E, SignImmE, PCPlus4E})
  );

  pipe_field_reg #(.W(3*REG_AW)) u_spec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (FlushE),
    .d     ({RsD, RtD, RdD}),
    .q     ({RsE, RtE, RdE})
  );

  // A constant 1 loaded alongside the instruction marks the slot as real.
  pipe_field_reg #(.W(1)) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_en),
    .clr   (FlushE),
    .d     (1'b1),
    .q     (ValidE)
  );

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemtoRegE   = ctrl_q.memto_reg;
  assign MemWriteE   = ctrl_q.mem_write;
  assign ALUControlE = ctrl_q.alu_control;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign RegDstE     = ctrl_q.reg_dst;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (FlushE) begin
      if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 32'd1;
    end else if (StallE) begin
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign BubbleCntE = bubble_cnt;
  assign StallCntE  = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: reset, directed vector table,
// hand sequences for stall/flush corners; counter checks with IDEX_PERF_CNT_EN.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
    logic [2:0]  aluc;
    logic        alu_src;
    logic        reg_dst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
  } fields_t;

  typedef struct {
    string   name;
    logic    stall;
    logic    flush;
    fields_t d;
    fields_t q;
    logic    valid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD, PCPlus4D;
  logic [4:0]  RsD, RtD, RdD;
  logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E;
  logic [4:0]  RsE, RtE, RdE;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] BubbleCntE, StallCntE;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .RegWriteD   (RegWriteD),
    .MemtoRegD   (MemtoRegD),
    .MemWriteD   (MemWriteD),
    .ALUControlD (ALUControlD),
    .ALUSrcD     (ALUSrcD),
    .RegDstD     (RegDstD),
    .RD1D        (RD1D),
    .RD2D        (RD2D),
    .RsD         (RsD),
    .RtD         (RtD),
    .RdD         (RdD),
    .SignImmD    (SignImmD),
    .PCPlus4D    (PCPlus4D),
    .RegWriteE   (RegWriteE),
    .MemtoRegE   (MemtoRegE),
    .MemWriteE   (MemWriteE),
    .ALUControlE (ALUControlE),
    .ALUSrcE     (ALUSrcE),
    .RegDstE     (RegDstE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .RsE         (RsE),
    .RtE         (RtE),
    .RdE         (RdE),
    .SignImmE    (SignImmE),
    .PCPlus4E    (PCPlus4E),
    .ValidE      (ValidE)
`ifdef IDEX_PERF_CNT_EN
    ,
    .BubbleCntE  (BubbleCntE),
    .StallCntE   (StallCntE)
`endif
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input fields_t f);
    RegWriteD   = f.reg_write;
    MemtoRegD   = f.memto_reg;
    MemWriteD   = f.mem_write;
    ALUControlD = f.aluc;
    ALUSrcD     = f.alu_src;
    RegDstD     = f.reg_dst;
    RD1D        = f.rd1;
    RD2D        = f.rd2;
    RsD         = f.rs;
    RtD         = f.rt;
    RdD         = f.rd;
    SignImmD    = f.imm;
    PCPlus4D    = f.pc4;
  endtask

  function automatic fields_t sample();
    fields_t f;
    f.reg_write = RegWriteE;
    f.memto_reg = MemtoRegE;
    f.mem_write = MemWriteE;
    f.aluc      = ALUControlE;
    f.alu_src   = ALUSrcE;
    f.reg_dst   = RegDstE;
    f.rd1       = RD1E;
    f.rd2       = RD2E;
    f.rs        = RsE;
    f.rt        = RtE;
    f.rd        = RdE;
    f.imm       = SignImmE;
    f.pc4       = PCPlus4E;
    return f;
  endfunction

  // Advance one rising edge and settle away from it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  fields_t fa, fa3, fb, fc, fz, fm;
  vec_t    vecs[12];

  initial begin
    fa  = '{reg_write:1'b1, memto_reg:1'b0, mem_write:1'b0, aluc:3'b010, alu_src:1'b0,
            reg_dst:1'b1, rd1:32'h0000_1111, rd2:32'h1234_5678, rs:5'd1, rt:5'd8,
            rd:5'd16, imm:32'hFFFF_FFFC, pc4:32'h0040_0004};
    fa3 = fa;
    fa3.rt = 5'd3;
    fb  = '{reg_write:1'b1, memto_reg:1'b1, mem_write:1'b0, aluc:3'b110, alu_src:1'b1,
            reg_dst:1'b0, rd1:32'hCAFE_F00D, rd2:32'h0, rs:5'd9, rt:5'd10,
            rd:5'd0, imm:32'h0000_0004, pc4:32'h0040_0008};
    fc  = '{reg_write:1'b0, memto_reg:1'b0, mem_write:1'b1, aluc:3'b010, alu_src:1'b1,
            reg_dst:1'b0, rd1:32'h1001_0000, rd2:32'hA5A5_A5A5, rs:5'd29, rt:5'd31,
            rd:5'd0, imm:32'h0000_0008, pc4:32'h0040_000C};
    fz  = '0;
    fm  = '1;

    vecs[0]  = '{"load_a",        1'b0, 1'b0, fa,  fa,  1'b1};
    vecs[1]  = '{"stall1",        1'b1, 1'b0, fa3, fa,  1'b1};
    vecs[2]  = '{"stall2",        1'b1, 1'b0, fa3, fa,  1'b1};
    vecs[3]  = '{"stall3",        1'b1, 1'b0, fa3, fa,  1'b1};
    vecs[4]  = '{"unstall_rt3",   1'b0, 1'b0, fa3, fa3, 1'b1};
    vecs[5]  = '{"load_b_rs9",    1'b0, 1'b0, fb,  fb,  1'b1};
    vecs[6]  = '{"flush",         1'b0, 1'b1, fc,  fz,  1'b0};
    vecs[7]  = '{"load_c_store",  1'b0, 1'b0, fc,  fc,  1'b1};
    vecs[8]  = '{"stall_flush",   1'b1, 1'b1, fb,  fz,  1'b0};
    vecs[9]  = '{"stall_bubble",  1'b1, 1'b0, fa,  fz,  1'b0};
    vecs[10] = '{"load_all_ones", 1'b0, 1'b0, fm,  fm,  1'b1};
    vecs[11] = '{"flush_ones",    1'b0, 1'b1, fa,  fz,  1'b0};

    // Reset with non-zero D inputs: everything reads as a bubble.
    drive(fa);
    RD1D = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    step();
    step();
    check("reset_fields", 160'(sample()), 160'(fz));
    check("reset_valid", 160'(ValidE), 160'(1'b0));
`ifdef IDEX_PERF_CNT_EN
    check("reset_cnts", 160'({BubbleCntE, StallCntE}), 160'(64'h0));
`endif

    rst_n = 1'b1;
    step();
    begin
      fields_t exp_rel;
      exp_rel = fa;
      exp_rel.rd1 = 32'hDEAD_BEEF;
      check("release_load", 160'({sample(), ValidE}), 160'({exp_rel, 1'b1}));
    end

    foreach (vecs[i]) begin
      drive(vecs[i].d);
      StallE = vecs[i].stall;
      FlushE = vecs[i].flush;
      step();
      check(vecs[i].name, 160'({sample(), ValidE}), 160'({vecs[i].q, vecs[i].valid}));
      if (vecs[i].name == "stall_flush")
        check("bubble_wreg", 160'({RegDstE, RtE, RegWriteE, MemWriteE}), 160'(0));
    end
    StallE = 1'b0;
    FlushE = 1'b0;

`ifdef IDEX_PERF_CNT_EN
    // Table applied 3 flush edges and 4 stall-only edges since reset.
    check("table_bubble_cnt", 160'(BubbleCntE), 160'(32'd3));
    check("table_stall_cnt", 160'(StallCntE), 160'(32'd4));
    StallE = 1'b1;
    FlushE = 1'b1;
    step();
    StallE = 1'b0;
    FlushE = 1'b0;
    check("simul_bubble_cnt", 160'(BubbleCntE), 160'(32'd4));
    check("simul_stall_cnt", 160'(StallCntE), 160'(32'd4));
`endif

    // Inputs changing between edges must not reach the outputs.
    drive(fb);
    step();
    drive(fc);
    #2;
    check("no_comb_path", 160'({sample(), ValidE}), 160'({fb, 1'b1}));

    // Reset released while stalled: bubble holds until the first plain load.
    drive(fa);
    StallE = 1'b1;
    rst_n = 1'b0;
    #2;
    check("async_reset", 160'({sample(), ValidE}), 160'(0));
    step();
    rst_n = 1'b1;
    step();
    step();
    check("rst_mid_stall", 160'({sample(), ValidE}), 160'(0));
    StallE = 1'b0;
    step();
    check("rst_stall_release", 160'({sample(), ValidE}), 160'({fa, 1'b1}));

`ifdef IDEX_PERF_CNT_EN
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    StallE = 1'b1;
    step();
    check("stall_cnt_reach_max", 160'(StallCntE), 160'(32'hFFFF_FFFF));
    step();
    step();
    check("stall_cnt_saturate", 160'(StallCntE), 160'(32'hFFFF_FFFF));
    check("sat_bubble_cnt", 160'(BubbleCntE), 160'(32'd0));
    StallE = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
